riscv_rf_wb_arbiter: RTL and testbench

Write-back arbiter and scheduler for the dual-write-port register file. Collects write-back requests from up to N_REQ producers (ALU, LSU, MULT, FPU) through valid/ready handshakes and maps up to two per cycle onto register-file write ports A and B. Outputs are registered and feed the register file's waddr/wdata/wtag/we inputs directly. Includes round-robin fairness, starvation escalation and same-address conflict avoidance.

---
 rtl/riscv_rf_arb_pkg.sv | 23 ++
 rtl/riscv_rr_picker.sv | 31 +++
 rtl/riscv_rf_wb_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_riscv_rf_wb_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_arb_pkg.sv
// Shared types, constants and helpers for the register-file write-back arbiter.
package riscv_rf_arb_pkg;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TAG_WIDTH  = 4;

  // Integer register x0: writes to it are accepted but never reach the register file
  localparam int X0_ADDR = 0;

  // One write-back request as seen by the register file
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_TAG_WIDTH-1:0]  tag;
  } wb_req_t;

  // Width of a wait counter that must be able to hold the value max_wait
  function automatic int wait_cnt_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/riscv_rr_picker.sv
// Round-robin find-first: picks the first set request bit at or after ptr, wrapping modulo N.
module riscv_rr_picker
  import riscv_rf_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Scan from the farthest offset back to ptr so the closest requester wins last
  always_comb begin
    gnt = '0;
    idx = '0;
    pos = '0;
    for (int off = N - 1; off >= 0; off--) begin
      pos = IDX_W'((int'(ptr) + off) % N);
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// Write-back arbiter for the dual-write-port register file: maps up to two
// requesters per cycle onto ports A and B with priority, round-robin fairness,
// starvation escalation and same-address conflict avoidance.
module riscv_rf_wb_arbiter
  import riscv_rf_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                                  clk_int,
  input  logic                                  rst_n,
  input  logic [N_REQ-1:0]                      req_valid_i,
  output logic [N_REQ-1:0]                      req_ready_o,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]      req_addr_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]      req_data_i,
  input  logic [N_REQ-1:0][TAG_WIDTH-1:0]       req_tag_i,
  output logic                                  we_a_o,
  output logic                                  we_b_o,
  output logic [ADDR_WIDTH-1:0]                 waddr_a_o,
  output logic [ADDR_WIDTH-1:0]                 waddr_b_o,
  output logic [DATA_WIDTH-1:0]                 wdata_a_o,
  output logic [DATA_WIDTH-1:0]                 wdata_b_o,
  output logic [TAG_WIDTH-1:0]                  wtag_a_o,
  output logic [TAG_WIDTH-1:0]                  wtag_b_o,
  output logic [N_REQ-1:0]                      urgent_o
);

  localparam int                    IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int                    CNT_W    = wait_cnt_width(MAX_WAIT);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_WAIT);
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(X0_ADDR);
  localparam logic [IDX_W-1:0]      RR_RESET = IDX_W'(1);

  logic [N_REQ-1:0][CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0]            rr_q;
  logic [IDX_W-1:0]            rr_next;

  logic [N_REQ-1:0]            x0_req;
  logic [N_REQ-1:0]            cand;
  logic [N_REQ-1:0]            urgent;
  logic [N_REQ-1:0]            urg_cand;

  logic [N_REQ-1:0]            rr_a_gnt;
  logic [IDX_W-1:0]            rr_a_idx;
  logic [N_REQ-1:0]            gnt_a;
  logic [IDX_W-1:0]            idx_a;
  logic                        a_by_rr;
  logic [ADDR_WIDTH-1:0]       addr_a;

  logic [N_REQ-1:0]            mask_b;
  logic [N_REQ-1:0]            gnt_b;
  logic [IDX_W-1:0]            idx_b;

  // Classify each requester: x0 writes bypass the ports, the rest compete for them
  always_comb begin
    x0_req = '0;
    cand   = '0;
    urgent = '0;
    for (int i = 0; i < N_REQ; i++) begin
      x0_req[i] = req_valid_i[i] && (req_addr_i[i] == ZERO_REG);
      cand[i]   = req_valid_i[i] && (req_addr_i[i] != ZERO_REG);
      urgent[i] = (cnt_q[i] == CNT_MAX);
    end
  end

  assign urgent_o = urgent;
  assign urg_cand = urgent & cand;

  riscv_rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick_a (
    .req (cand),
    .ptr (rr_q),
    .gnt (rr_a_gnt),
    .idx (rr_a_idx)
  );

  // Port A: lowest-index urgent requester, else the ALU, else the round-robin winner
  always_comb begin
    gnt_a   = '0;
    idx_a   = '0;
    a_by_rr = 1'b0;
    if (|urg_cand) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (urg_cand[i]) begin
          gnt_a    = '0;
          gnt_a[i] = 1'b1;
          idx_a    = IDX_W'(i);
        end
      end
    end else if (cand[0]) begin
      gnt_a[0] = 1'b1;
      idx_a    = '0;
    end else if (|rr_a_gnt) begin
      gnt_a   = rr_a_gnt;
      idx_a   = rr_a_idx;
      a_by_rr = 1'b1;
    end
  end

  assign addr_a = req_addr_i[idx_a];

  // Port B candidates exclude the port-A winner and anything aimed at the same register
  always_comb begin
    mask_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask_b[i] = cand[i] && !gnt_a[i] && (req_addr_i[i] != addr_a);
    end
  end

  riscv_rr_picker #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick_b (
    .req (mask_b),
    .ptr (rr_q),
    .gnt (gnt_b),
    .idx (idx_b)
  );

  // Accept granted requesters and x0 writes; nothing is accepted while reset is held
  always_comb begin
    req_ready_o = '0;
    if (rst_n) begin
      req_ready_o = x0_req | gnt_a | gnt_b;
    end
  end

  // Pointer moves past the last requester that won through round-robin this cycle
  always_comb begin
    rr_next = rr_q;
    if (|gnt_b) begin
      rr_next = IDX_W'((int'(idx_b) + 1) % N_REQ);
    end else if (a_by_rr) begin
      rr_next = IDX_W'((int'(idx_a) + 1) % N_REQ);
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= RR_RESET;
    end else begin
      rr_q <= rr_next;
    end
  end

  // Wait counters count stalled cycles, saturating; any transfer or idle cycle clears them
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid_i[i] && !req_ready_o[i]) begin
          if (cnt_q[i] != CNT_MAX) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // Port A output register: payload only loads on a grant so the bus holds when idle
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      we_a_o    <= 1'b0;
      waddr_a_o <= '0;
      wdata_a_o <= '0;
      wtag_a_o  <= '0;
    end else begin
      we_a_o <= |gnt_a;
      if (|gnt_a) begin
        waddr_a_o <= req_addr_i[idx_a];
        wdata_a_o <= req_data_i[idx_a];
        wtag_a_o  <= req_tag_i[idx_a];
      end
    end
  end

  // Port B output register, same hold behaviour as port A
  always_ff @(posedge clk_int or negedge rst_n) begin
    if (!rst_n) begin
      we_b_o    <= 1'b0;
      waddr_b_o <= '0;
      wdata_b_o <= '0;
      wtag_b_o  <= '0;
    end else begin
      we_b_o <= |gnt_b;
      if (|gnt_b) begin
        waddr_b_o <= req_addr_i[idx_b];
        wdata_b_o <= req_data_i[idx_b];
        wtag_b_o  <= req_tag_i[idx_b];
      end
    end
  end

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// Scoreboard bench for riscv_rf_wb_arbiter: directed vectors push expected
// register-file writes, an independent monitor pops and compares them.
module tb_riscv_rf_wb_arbiter;
  import riscv_rf_arb_pkg::*;

  localparam int N_REQ      = 4;
  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 4;
  localparam int MAX_WAIT   = 8;

  typedef logic [N_REQ-1:0][ADDR_WIDTH-1:0] addr_vec_t;

  typedef struct {
    wb_req_t req;
    int      cyc;
  } exp_t;

  logic                                 clk_int = 1'b0;
  logic                                 rst_n   = 1'b0;
  logic [N_REQ-1:0]                     req_valid_i = '0;
  logic [N_REQ-1:0]                     req_ready_o;
  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr_i = '0;
  logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_data_i = '0;
  logic [N_REQ-1:0][TAG_WIDTH-1:0]      req_tag_i  = '0;
  logic                                 we_a_o, we_b_o;
  logic [ADDR_WIDTH-1:0]                waddr_a_o, waddr_b_o;
  logic [DATA_WIDTH-1:0]                wdata_a_o, wdata_b_o;
  logic [TAG_WIDTH-1:0]                 wtag_a_o, wtag_b_o;
  logic [N_REQ-1:0]                     urgent_o;

  exp_t expA[$];
  exp_t expB[$];
  int   nChecks = 0;
  int   nFails  = 0;
  int   cyc     = 0;
  int   seqNum[N_REQ];

  always #5 clk_int = ~clk_int;

  always @(posedge clk_int) cyc <= cyc + 1;

  riscv_rf_wb_arbiter #(
    .N_REQ      (N_REQ),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH),
    .MAX_WAIT   (MAX_WAIT)
  ) dut (
    .clk_int     (clk_int),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_tag_i   (req_tag_i),
    .we_a_o      (we_a_o),
    .we_b_o      (we_b_o),
    .waddr_a_o   (waddr_a_o),
    .waddr_b_o   (waddr_b_o),
    .wdata_a_o   (wdata_a_o),
    .wdata_b_o   (wdata_b_o),
    .wtag_a_o    (wtag_a_o),
    .wtag_b_o    (wtag_b_o),
    .urgent_o    (urgent_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic addr_vec_t addrs4(input int a0, input int a1, input int a2, input int a3);
    addr_vec_t v;
    v[0] = ADDR_WIDTH'(a0);
    v[1] = ADDR_WIDTH'(a1);
    v[2] = ADDR_WIDTH'(a2);
    v[3] = ADDR_WIDTH'(a3);
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] dataOf(input int idx, input int s, input logic [ADDR_WIDTH-1:0] a);
    return {4'(idx), 4'h0, 8'(s), 10'h0, a};
  endfunction

  // Drive one cycle of requests at the falling edge, check ready/urgent, and queue expected writes
  task automatic applyStimulus(input bit rstVal, input logic [N_REQ-1:0] valid, input addr_vec_t addrs,
                               input logic [N_REQ-1:0] expReady, input int gA, input int gB,
                               input logic [N_REQ-1:0] expUrg);
    exp_t e;
    @(negedge clk_int);
    rst_n       = rstVal;
    req_valid_i = valid;
    req_addr_i  = addrs;
    for (int i = 0; i < N_REQ; i++) begin
      req_data_i[i] = dataOf(i, seqNum[i], addrs[i]);
      req_tag_i[i]  = TAG_WIDTH'(seqNum[i] + i);
    end
    #1;
    checkOutput("ready", 64'(req_ready_o), 64'(expReady));
    checkOutput("urgent", 64'(urgent_o), 64'(expUrg));
    if (gA >= 0) begin
      e.req.addr = addrs[gA];
      e.req.data = req_data_i[gA];
      e.req.tag  = req_tag_i[gA];
      e.cyc      = cyc + 1;
      expA.push_back(e);
    end
    if (gB >= 0) begin
      e.req.addr = addrs[gB];
      e.req.data = req_data_i[gB];
      e.req.tag  = req_tag_i[gB];
      e.cyc      = cyc + 1;
      expB.push_back(e);
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (expReady[i] && valid[i]) seqNum[i]++;
    end
  endtask

  // Compare one write port against the head of its expectation queue
  task automatic checkPort(input string nm, input logic we, input logic [ADDR_WIDTH-1:0] a,
                           input logic [DATA_WIDTH-1:0] d, input logic [TAG_WIDTH-1:0] t, input bit isB);
    exp_t e;
    bit   have;
    have = isB ? (expB.size() > 0) : (expA.size() > 0);
    if (have) e = isB ? expB[0] : expA[0];
    if (we) begin
      if (!have) begin
        checkOutput({nm, "_we_unexpected"}, 64'(we), 64'(0));
      end else begin
        if (isB) void'(expB.pop_front()); else void'(expA.pop_front());
        checkOutput({nm, "_addr"}, 64'(a), 64'(e.req.addr));
        checkOutput({nm, "_data"}, 64'(d), 64'(e.req.data));
        checkOutput({nm, "_tag"}, 64'(t), 64'(e.req.tag));
        checkOutput({nm, "_cycle"}, 64'(cyc), 64'(e.cyc));
      end
    end else if (have && e.cyc <= cyc) begin
      if (isB) void'(expB.pop_front()); else void'(expA.pop_front());
      checkOutput({nm, "_we_missing"}, 64'(we), 64'(1));
    end
  endtask

  // Monitor: sample registered outputs on the falling edge, away from the active edge
  initial begin
    forever begin
      @(negedge clk_int);
      checkPort("port_a", we_a_o, waddr_a_o, wdata_a_o, wtag_a_o, 1'b0);
      checkPort("port_b", we_b_o, waddr_b_o, wdata_b_o, wtag_b_o, 1'b1);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) seqNum[i] = 0;

    // Reset held with every requester valid: nothing accepted, outputs cleared
    applyStimulus(1'b0, 4'b1111, addrs4(5, 6, 7, 8), 4'b0000, -1, -1, 4'b0000);
    applyStimulus(1'b0, 4'b1111, addrs4(5, 6, 7, 8), 4'b0000, -1, -1, 4'b0000);
    checkOutput("reset_we_a", 64'(we_a_o), 64'(0));
    checkOutput("reset_we_b", 64'(we_b_o), 64'(0));
    checkOutput("reset_waddr_a", 64'(waddr_a_o), 64'(0));
    checkOutput("reset_wdata_b", 64'(wdata_b_o), 64'(0));
    checkOutput("reset_wtag_a", 64'(wtag_a_o), 64'(0));

    // First cycle after release: ALU to x5 on A, req2 to x7 on B (rr_q=1 -> 2, then 3)
    applyStimulus(1'b1, 4'b0101, addrs4(5, 0, 7, 0), 4'b0101, 0, 2, 4'b0000);

    // All four valid on x1..x4: ALU always on A, B rotates 3,1,2,3
    applyStimulus(1'b1, 4'b1111, addrs4(1, 2, 3, 4), 4'b1001, 0, 3, 4'b0000);
    applyStimulus(1'b1, 4'b1111, addrs4(1, 2, 3, 4), 4'b0011, 0, 1, 4'b0000);
    applyStimulus(1'b1, 4'b1111, addrs4(1, 2, 3, 4), 4'b0101, 0, 2, 4'b0000);
    applyStimulus(1'b1, 4'b1111, addrs4(1, 2, 3, 4), 4'b1001, 0, 3, 4'b0000);
    applyStimulus(1'b1, 4'b0000, addrs4(0, 0, 0, 0), 4'b0000, -1, -1, 4'b0000);

    // Same-address conflict on x9: ALU first, req1 retries and wins via round-robin (rr_q=0)
    applyStimulus(1'b1, 4'b0011, addrs4(9, 9, 0, 0), 4'b0001, 0, -1, 4'b0000);
    applyStimulus(1'b1, 4'b0010, addrs4(0, 9, 0, 0), 4'b0010, 1, -1, 4'b0000);

    // x0 write from req3 accepted without a port; only x4 written
    applyStimulus(1'b1, 4'b1010, addrs4(0, 4, 0, 0), 4'b1010, 1, -1, 4'b0000);
    // f0 (address 32) is an ordinary register, x0 from req1 accepted silently
    applyStimulus(1'b1, 4'b0011, addrs4(32, 0, 0, 0), 4'b0011, 0, -1, 4'b0000);

    // Starvation: req1 blocked behind the ALU on x9 for MAX_WAIT cycles, then takes port A
    for (int k = 0; k < MAX_WAIT; k++) begin
      applyStimulus(1'b1, 4'b0011, addrs4(9, 9, 0, 0), 4'b0001, 0, -1, 4'b0000);
    end
    applyStimulus(1'b1, 4'b0011, addrs4(9, 9, 0, 0), 4'b0010, 1, -1, 4'b0010);
    applyStimulus(1'b1, 4'b0011, addrs4(9, 9, 0, 0), 4'b0001, 0, -1, 4'b0000);

    // Asynchronous reset while a write is on port A
    applyStimulus(1'b1, 4'b0001, addrs4(12, 0, 0, 0), 4'b0001, 0, -1, 4'b0000);
    @(posedge clk_int);
    #2;
    checkOutput("we_a_before_reset", 64'(we_a_o), 64'(1));
    checkOutput("waddr_a_before_reset", 64'(waddr_a_o), 64'(12));
    rst_n = 1'b0;
    #1;
    checkOutput("we_a_async_reset", 64'(we_a_o), 64'(0));
    checkOutput("waddr_a_async_reset", 64'(waddr_a_o), 64'(0));
    checkOutput("wdata_a_async_reset", 64'(wdata_a_o), 64'(0));
    expA.delete();
    expB.delete();
    applyStimulus(1'b0, 4'b0000, addrs4(0, 0, 0, 0), 4'b0000, -1, -1, 4'b0000);

    // After release rr_q is 1 again: A=1, B=2; then A=3, B=1; then A=2, B=3
    applyStimulus(1'b1, 4'b1110, addrs4(0, 1, 2, 3), 4'b0110, 1, 2, 4'b0000);
    applyStimulus(1'b1, 4'b1110, addrs4(0, 1, 2, 3), 4'b1010, 3, 1, 4'b0000);
    applyStimulus(1'b1, 4'b1110, addrs4(0, 1, 2, 3), 4'b1100, 2, 3, 4'b0000);
    applyStimulus(1'b1, 4'b0000, addrs4(0, 0, 0, 0), 4'b0000, -1, -1, 4'b0000);

    repeat (3) @(negedge clk_int);
    #1;
    checkOutput("port_a_pending", 64'(expA.size()), 64'(0));
    checkOutput("port_b_pending", 64'(expB.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
